// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer with two-flop rx synchroniser, mid-bit sampling and stop-bit check.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_frame #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t        state_q, state_d;
    logic          sync_q, rx_s_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          bit_end;
    logic [TW-1:0] tick_next;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
`endif

    // Explicit wrap keeps non-power-of-two oversampling ratios exact.
    assign bit_end   = tick_cnt_q == LAST;
    assign tick_next = bit_end ? '0 : tick_cnt_q + TW'(1);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                    if (tick_cnt_q == HALF) begin
                        state_d    = rx_s_q ? IDLE : DATA;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end
                end
                DATA: begin
                    tick_cnt_d = tick_next;
                    if (bit_end) begin
                        shift_d[bit_cnt_q[2:0]] = rx_s_q;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        state_d   = (bit_cnt_q == BLAST) ? AFTER_DATA : DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    tick_cnt_d = tick_next;
                    if (bit_end) begin
                        par_d   = rx_s_q;
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    tick_cnt_d = tick_next;
                    if (bit_end) begin
                        state_d     = rx_s_q ? IDLE : BREAK_WAIT;
                        rx_valid_d  = rx_s_q;
                        frame_err_d = !rx_s_q;
                        rx_data_d   = rx_s_q ? shift_q : rx_data_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^shift_q[DATA_BITS-1:0] ^ par_q;
`endif
                    end
                end
                // A held-low line parks here so a break raises only one frame_err.
                BREAK_WAIT: state_d = rx_s_q ? IDLE : BREAK_WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= rx;
            rx_s_q      <= sync_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed UART frames checked against an event-level model of delivered words and errors.
`timescale 1ns/1ps
module tb_uart_rx_frame;
    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int LAT = 171;
`else
    localparam bit PAR = 1'b0;
    localparam int LAT = 155;
`endif

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst, baud_tick, rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, busy;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         tests = 0, fails = 0;
    int         cyc = 0, last_valid_cyc = 0;
    int         vcnt = 0, fe_cnt = 0, pcnt = 0;
    int         div = 1;
    bit         chk = 1'b0, prev_v = 1'b0, prev_f = 1'b0;
    int         t0, v0;

    uart_rx_frame dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit stop_b, input bit pb);
        int bc;
        ev_t e;
        bc = OS * div;
        e.ferr = !stop_b;
        e.data = d;
        e.perr = PAR ? (^d ^ pb) : 1'b0;
        exp_q.push_back(e);
        rx = 1'b0;
        idle(bc);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            idle(bc);
        end
        if (PAR) begin
            rx = pb;
            idle(bc);
        end
        rx = stop_b;
        idle(bc);
    endtask

    initial begin
        int ph;
        ph = 0;
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % div;
            baud_tick = (ph == 0);
        end
    end

    always @(negedge clk) begin : cmp
        ev_t e;
        if (chk) begin
            if (rx_valid === 1'b1) begin
                vcnt++;
                last_valid_cyc = cyc;
            end
            if (frame_err === 1'b1) fe_cnt++;
            if (parity_err === 1'b1) pcnt++;
            if ((rx_valid !== 1'b0) || (frame_err !== 1'b0)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected pulse", {rx_valid, frame_err}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse kind", {rx_valid, frame_err}, {!e.ferr, e.ferr});
                    check("parity_err", parity_err, e.perr);
                    if (!e.ferr) model_data = e.data;
                end
            end else begin
                check("stray parity_err", parity_err, 1'b0);
            end
            check("rx_data", rx_data, model_data);
            check("pulse width", {rx_valid & prev_v, frame_err & prev_f}, 2'b00);
            prev_v = (rx_valid === 1'b1);
            prev_f = (frame_err === 1'b1);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        idle(3);
        rst = 1'b0;
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset parity_err", parity_err, 1'b0);
        check("reset busy", busy, 1'b0);
        chk = 1'b1;
        idle(4);

        t0 = cyc;
        send(8'hA5, 1'b1, ^8'hA5);
        idle(20);
        check("a5 latency", last_valid_cyc - t0, LAT);
        check("a5 data", rx_data, 8'hA5);
        check("a5 busy", busy, 1'b0);
        check("a5 ferr", fe_cnt, 0);
        check("a5 pending", exp_q.size(), 0);

        v0 = vcnt;
        rx = 1'b0;
        idle(5);
        check("glitch busy", busy, 1'b1);
        rx = 1'b1;
        idle(2 * OS);
        check("glitch idle", busy, 1'b0);
        check("glitch no valid", vcnt - v0, 0);
        check("glitch no ferr", fe_cnt, 0);
        send(8'h3C, 1'b1, ^8'h3C);
        idle(20);
        check("3c data", rx_data, 8'h3C);
        check("3c pending", exp_q.size(), 0);

        send(8'h55, 1'b0, ^8'h55);
        idle(100);
        check("break busy", busy, 1'b1);
        check("break ferr count", fe_cnt, 1);
        check("break data held", rx_data, 8'h3C);
        rx = 1'b1;
        idle(40);
        check("break release", busy, 1'b0);
        check("break ferr once", fe_cnt, 1);
        check("break pending", exp_q.size(), 0);

        div = 4;
        idle(8);
        v0 = vcnt;
        send(8'h00, 1'b1, ^8'h00);
        send(8'hFF, 1'b1, ^8'hFF);
        send(8'h81, 1'b1, ^8'h81);
        idle(2 * OS * 4);
        check("b2b count", vcnt - v0, 3);
        check("b2b last", rx_data, 8'h81);
        check("b2b ferr", fe_cnt, 1);
        check("b2b pending", exp_q.size(), 0);

        div = 1;
        idle(8);
        v0 = vcnt;
        rx = 1'b0;
        idle(OS);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h12 >> i) & 8'h01;
            idle(OS);
        end
        rx = 1'b0;
        idle(OS / 2);
        rst = 1'b1;
        rx  = 1'b1;
        idle(1);
        rst = 1'b0;
        model_data = 8'h00;
        check("rst rx_data", rx_data, 8'h00);
        check("rst rx_valid", rx_valid, 1'b0);
        check("rst frame_err", frame_err, 1'b0);
        check("rst parity_err", parity_err, 1'b0);
        check("rst busy", busy, 1'b0);
        idle(3 * OS);
        check("rst no pulse", vcnt - v0, 0);
        send(8'h12, 1'b1, ^8'h12);
        idle(20);
        check("12 data", rx_data, 8'h12);
        check("12 pending", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        pcnt = 0;
        send(8'h07, 1'b1, 1'b0);
        idle(20);
        check("par bad count", pcnt, 1);
        check("par bad data", rx_data, 8'h07);
        send(8'h07, 1'b1, 1'b1);
        idle(20);
        check("par good count", pcnt, 1);
        check("par pending", exp_q.size(), 0);
`else
        check("no parity pulses", pcnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
